// File: rtl/shifter_pkg.sv
// Opcode constants and small decode helpers shared by the shifter pipeline
// and the ALU decoder.
package shifter_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  function automatic logic op_legal(input logic [2:0] op);
    return (op <= OP_ROR);
  endfunction

  function automatic logic op_rotate(input logic [2:0] op);
    return (op == OP_ROL) || (op == OP_ROR);
  endfunction

endpackage

// File: rtl/shift_level.sv
// One mux level of the barrel shifter: shifts or rotates by SHIFT when amt_bit
// is set, otherwise (or for an illegal opcode) passes the data straight through.
module shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHIFT = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             amt_bit,
  input  logic [2:0]       op,
  input  logic             fill,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = data;
    if (amt_bit) begin
      case (op)
        OP_SLL:         result = {data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}};
        OP_SRL, OP_SRA: result = {{SHIFT{fill}}, data[WIDTH-1:SHIFT]};
        OP_ROL:         result = {data[WIDTH-SHIFT-1:0], data[WIDTH-1:WIDTH-SHIFT]};
        OP_ROR:         result = {data[SHIFT-1:0], data[WIDTH-1:SHIFT]};
        default:        result = data;
      endcase
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter/rotator with valid/ready handshake, a global stall
// and a register after every REG_EVERY mux levels.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int REG_EVERY = 1,
  parameter int TAG_W     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic [$clog2(WIDTH)-1:0] in_amt,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic                     out_err,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int AW = $clog2(WIDTH);
  localparam int NG = (AW + REG_EVERY - 1) / REG_EVERY;

  typedef struct packed {
    logic             valid;
    logic [2:0]       op;
    logic [AW-1:0]    amt;
    logic [WIDTH-1:0] data;
    logic             cand;
    logic             err;
    logic [TAG_W-1:0] tag;
  } stage_t;

  stage_t in_pl;
  stage_t gin  [NG];
  stage_t gout [NG];
  stage_t st   [NG];
  stage_t last;
  logic   zero_q;
  logic   stall;
  logic   rot_bit;
  logic [AW-1:0] neg_amt;
  logic [AW-1:0] amt_m1;

  assign last     = st[NG-1];
  assign stall    = last.valid && !out_ready;
  assign in_ready = !rst && !stall;
  assign neg_amt  = -in_amt;
  assign amt_m1   = in_amt - AW'(1);

  // Shifts know their carry from the operand; rotates only mark amt != 0 here
  // and pick the wrapped bit from the final result.
  always_comb begin
    in_pl       = '0;
    in_pl.valid = in_valid && in_ready;
    in_pl.op    = in_op;
    in_pl.amt   = in_amt;
    in_pl.data  = in_data;
    in_pl.tag   = in_tag;
    in_pl.err   = !op_legal(in_op);
    in_pl.cand  = 1'b0;
    if (in_amt != '0) begin
      case (in_op)
        OP_SLL:         in_pl.cand = in_data[neg_amt];
        OP_SRL, OP_SRA: in_pl.cand = in_data[amt_m1];
        OP_ROL, OP_ROR: in_pl.cand = 1'b1;
        default:        in_pl.cand = 1'b0;
      endcase
    end
  end

  for (genvar g = 0; g < NG; g++) begin : g_group
    localparam int LAST = (((g + 1) * REG_EVERY < AW) ? (g + 1) * REG_EVERY : AW) - 1;
    if (g == 0) begin : g_head
      assign gin[g] = in_pl;
    end else begin : g_tail
      assign gin[g] = st[g-1];
    end
    assign gout[g] = {gin[g].valid, gin[g].op, gin[g].amt, g_level[LAST].lout,
                      gin[g].cand, gin[g].err, gin[g].tag};
  end

  // Level j handles amount bit AW-1-j, so the largest shift comes first.
  for (genvar j = 0; j < AW; j++) begin : g_level
    localparam int G = j / REG_EVERY;
    localparam int K = AW - 1 - j;
    logic [WIDTH-1:0] lin;
    logic [WIDTH-1:0] lout;
    logic             fill;
    if (j % REG_EVERY == 0) begin : g_first
      assign lin = gin[G].data;
    end else begin : g_chain
      assign lin = g_level[j-1].lout;
    end
    assign fill = (gin[G].op == OP_SRA) ? lin[WIDTH-1] : 1'b0;
    shift_level #(.WIDTH(WIDTH), .SHIFT(1 << K)) u_level (
      .data    (lin),
      .amt_bit (gin[G].amt[K]),
      .op      (gin[G].op),
      .fill    (fill),
      .result  (lout)
    );
  end

  // A stall freezes every stage at once, bubbles included.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int g = 0; g < NG; g++) st[g] <= '0;
      zero_q <= 1'b0;
    end else if (!stall) begin
      for (int g = 0; g < NG; g++) st[g] <= gout[g];
      zero_q <= ~|gout[NG-1].data;
    end
  end

  assign rot_bit   = (last.op == OP_ROL) ? last.data[0] : last.data[WIDTH-1];
  assign out_valid = last.valid;
  assign out_data  = last.data;
  assign out_carry = last.cand & (!op_rotate(last.op) | ((|last.amt) & rot_bit));
  assign out_zero  = zero_q;
  assign out_err   = last.err;
  assign out_tag   = last.tag;

endmodule

// File: tb/tb_pipe_shifter.sv
// Self-checking bench: three pipe_shifter configurations driven in parallel,
// directed vectors on the 32-bit instance plus a randomised scoreboard sweep.
module tb_pipe_shifter;
  import shifter_pkg::*;

  localparam int LAT32 = 5;
  localparam int LAT8  = 1;
  localparam int LAT64 = 3;

  typedef struct {
    logic [2:0]  op;
    logic [5:0]  amt;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_carry;
    logic        exp_zero;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    logic        carry;
    logic        zero;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [2:0]  in_op;
  logic [5:0]  in_amt;
  logic [63:0] in_data;
  logic [3:0]  in_tag;

  logic rdy32, ov32, oc32, oz32, oe32;
  logic [31:0] od32;
  logic [3:0]  ot32;
  logic rdy8, ov8, oc8, oz8, oe8;
  logic [7:0]  od8;
  logic [3:0]  ot8;
  logic rdy64, ov64, oc64, oz64, oe64;
  logic [63:0] od64;
  logic [3:0]  ot64;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q [3][$];
  bit   held [3];
  exp_t hold_v [3];
  vec_t vecs [10];

  always #5 clk = ~clk;

  pipe_shifter #(.WIDTH(32), .REG_EVERY(1), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_op(in_op),
    .in_amt(in_amt[4:0]), .in_data(in_data[31:0]), .in_tag(in_tag),
    .out_valid(ov32), .out_ready(out_ready), .out_data(od32), .out_carry(oc32),
    .out_zero(oz32), .out_err(oe32), .out_tag(ot32));

  pipe_shifter #(.WIDTH(8), .REG_EVERY(3), .TAG_W(4)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy8), .in_op(in_op),
    .in_amt(in_amt[2:0]), .in_data(in_data[7:0]), .in_tag(in_tag),
    .out_valid(ov8), .out_ready(out_ready), .out_data(od8), .out_carry(oc8),
    .out_zero(oz8), .out_err(oe8), .out_tag(ot8));

  pipe_shifter #(.WIDTH(64), .REG_EVERY(2), .TAG_W(4)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_op(in_op),
    .in_amt(in_amt), .in_data(in_data), .in_tag(in_tag),
    .out_valid(ov64), .out_ready(out_ready), .out_data(od64), .out_carry(oc64),
    .out_zero(oz64), .out_err(oe64), .out_tag(ot64));

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  // Reference result computed arithmetically on a w-bit operand.
  function automatic void model(input int w, input logic [2:0] op, input int amt,
                                input logic [63:0] din, output exp_t e);
    logic [63:0] mask, d, r;
    logic        c;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    d = din & mask;
    r = d;
    c = 1'b0;
    e.err = 1'b0;
    case (op)
      OP_SLL: begin r = (d << amt) & mask; if (amt != 0) c = d[w-amt]; end
      OP_SRL: begin r = d >> amt; if (amt != 0) c = d[amt-1]; end
      OP_SRA: begin
        r = d >> amt;
        if (d[w-1]) r = r | (mask & ~(mask >> amt));
        if (amt != 0) c = d[amt-1];
      end
      OP_ROL: begin r = ((d << amt) | (d >> (w - amt))) & mask; if (amt != 0) c = r[0]; end
      OP_ROR: begin r = ((d >> amt) | (d << (w - amt))) & mask; if (amt != 0) c = r[w-1]; end
      default: e.err = 1'b1;
    endcase
    e.data  = r;
    e.carry = c;
    e.zero  = (r == 64'd0);
    e.tag   = in_tag;
  endfunction

  task automatic checkOutput(input int idx, input int w, input logic rdy, input logic ov,
                             input logic [63:0] od, input logic oc, input logic oz,
                             input logic oe, input logic [3:0] ot);
    exp_t e, cur;
    cur = '{od, oc, oz, oe, ot};
    if (rst) begin
      check($sformatf("w%0d_ready_in_reset", w), 64'(rdy), 64'd0);
      exp_q[idx].delete();
      held[idx] = 1'b0;
    end else begin
      check($sformatf("w%0d_ready_vs_stall", w), 64'(rdy), 64'(!(ov && !out_ready)));
      if (held[idx]) begin
        check($sformatf("w%0d_stable_data", w), od, hold_v[idx].data);
        check($sformatf("w%0d_stable_flags", w), 64'({oc, oz, oe, ot}),
              64'({hold_v[idx].carry, hold_v[idx].zero, hold_v[idx].err, hold_v[idx].tag}));
      end
      if (ov && out_ready) begin
        if (exp_q[idx].size() == 0) begin
          check($sformatf("w%0d_unexpected_result", w), 64'(ov), 64'd0);
        end else begin
          e = exp_q[idx].pop_front();
          check($sformatf("w%0d_data", w), od, e.data);
          check($sformatf("w%0d_carry", w), 64'(oc), 64'(e.carry));
          check($sformatf("w%0d_zero", w), 64'(oz), 64'(e.zero));
          check($sformatf("w%0d_err", w), 64'(oe), 64'(e.err));
          check($sformatf("w%0d_tag", w), 64'(ot), 64'(e.tag));
        end
      end
      held[idx]   = ov && !out_ready;
      hold_v[idx] = cur;
      if (in_valid && rdy) begin
        model(w, in_op, int'(in_amt) & (w - 1), in_data, e);
        exp_q[idx].push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    checkOutput(0, 32, rdy32, ov32, {32'd0, od32}, oc32, oz32, oe32, ot32);
    checkOutput(1, 8,  rdy8,  ov8,  {56'd0, od8},  oc8,  oz8,  oe8,  ot8);
    checkOutput(2, 64, rdy64, ov64, od64,          oc64, oz64, oe64, ot64);
  end

  // One operation with out_ready high; checks the 32-bit result and all latencies.
  task automatic applyStimulus(input vec_t v, input logic [3:0] tag);
    int lat [3];
    lat = '{-1, -1, -1};
    in_valid = 1'b1;
    in_op    = v.op;
    in_amt   = v.amt;
    in_data  = {$urandom, v.data};
    in_tag   = tag;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (lat[0] < 0 && ov32) begin
        lat[0] = c;
        check("vec_data", 64'(od32), 64'(v.exp_data));
        check("vec_carry", 64'(oc32), 64'(v.exp_carry));
        check("vec_zero", 64'(oz32), 64'(v.exp_zero));
        check("vec_err", 64'(oe32), 64'(v.exp_err));
        check("vec_tag", 64'(ot32), 64'(tag));
      end
      if (lat[1] < 0 && ov8)  lat[1] = c;
      if (lat[2] < 0 && ov64) lat[2] = c;
      if (lat[0] >= 0 && lat[1] >= 0 && lat[2] >= 0) break;
      @(posedge clk); #1;
    end
    check("latency_w32", 64'(lat[0]), 64'(LAT32));
    check("latency_w8",  64'(lat[1]), 64'(LAT8));
    check("latency_w64", 64'(lat[2]), 64'(LAT64));
  endtask

  task automatic checkResetState();
    check("rst_out_valid", 64'(ov32), 64'd0);
    check("rst_out_data", 64'(od32), 64'd0);
    check("rst_out_flags", 64'({oc32, oz32, oe32}), 64'd0);
    check("rst_out_tag", 64'(ot32), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "[TB] simulation timeout");
  end

  initial begin
    int sent, got;
    logic [2:0]  sop  [8];
    logic [5:0]  samt [8];
    logic [63:0] sdat [8];

    vecs[0] = '{OP_SRA, 6'd4,  32'h80000010, 32'hF8000001, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{OP_ROL, 6'd1,  32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{OP_SLL, 6'd31, 32'h00000002, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{3'b110, 6'd5,  32'h1234ABCD, 32'h1234ABCD, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{OP_SRL, 6'd8,  32'h80000000, 32'h00800000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{OP_ROR, 6'd4,  32'h0000000F, 32'hF0000000, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{OP_SLL, 6'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{OP_SRA, 6'd31, 32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{OP_ROR, 6'd0,  32'h00000001, 32'h00000001, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{OP_SRA, 6'd1,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_amt = '0; in_data = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState();
    check("ready_during_reset", 64'(rdy32), 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", 64'(rdy32), 64'd1);

    $display("[TB] directed vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i], 4'(i));
      repeat (2) @(posedge clk);
      #1;
    end

    $display("[TB] back-to-back tags with stall window");
    for (int i = 0; i < 8; i++) begin
      sop[i]  = 3'($urandom_range(0, 4));
      samt[i] = 6'($urandom);
      sdat[i] = {$urandom, $urandom};
    end
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc <= 6);
      in_valid  = (sent < 8);
      if (sent < 8) begin
        in_op = sop[sent]; in_amt = samt[sent]; in_data = sdat[sent]; in_tag = 4'(sent);
      end
      @(negedge clk);
      if (ov32 && out_ready) begin
        check("seq_tag_order", 64'(ot32), 64'(got));
        got++;
      end
      if (in_valid && rdy32) sent++;
      @(posedge clk); #1;
    end
    check("seq_all_tags", 64'(got), 64'd8);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    $display("[TB] reset with operations in flight");
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_op = OP_SLL; in_amt = 6'(i + 1);
      in_data = {$urandom, $urandom}; in_tag = 4'(9 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkResetState();
    for (int i = 0; i < 6; i++) begin
      check("no_stale_result", 64'(ov32), 64'd0);
      @(posedge clk); #1;
    end
    applyStimulus(vecs[0], 4'd12);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] randomised sweep");
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_op     = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
      in_amt    = 6'($urandom);
      in_data   = {$urandom, $urandom};
      in_tag    = 4'($urandom);
      rst       = (i == 700);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("drain_w32", 64'(exp_q[0].size()), 64'd0);
    check("drain_w8",  64'(exp_q[1].size()), 64'd0);
    check("drain_w64", 64'(exp_q[2].size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_shifter.md
PIPE_SHIFTER -- requirements
Module: pipe_shifter

Interface
REQ-001 Parameter WIDTH, default 32, data width; SHALL be a power of two, 8 to 64.
REQ-002 Parameter REG_EVERY, default 1, number of mux levels between pipeline registers; SHALL be 1 to log2(WIDTH).
REQ-003 Parameter TAG_W, default 4, width of the sideband tag carried with each operation.
REQ-004 Ports SHALL be, in order:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready.
- in_op  in  3  000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, 101–111 illegal.
- in_amt  in  log2(WIDTH)  shift/rotate amount.
- in_data  in  WIDTH  operand.
- in_tag  in  TAG_W  opaque tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_data  out  WIDTH  result.
- out_carry  out  1  last bit shifted or rotated out.
- out_zero  out  1  out_data == 0.
- out_err  out  1  illegal opcode.
- out_tag  out  TAG_W  tag of this result.

Function
REQ-005 The datapath SHALL be log2(WIDTH) mux levels, MSB amount bit first. Level k SHALL shift by 2^k when amt[k] = 1.
REQ-006 A pipeline register SHALL follow every REG_EVERY levels, with the last group always registered. Latency L = ceil(log2(WIDTH)/REG_EVERY) cycles from acceptance to out_valid with no stall; WIDTH=32, REG_EVERY=1 gives L=5.
REQ-007 Fill bit for SRA SHALL be in_data[WIDTH-1]. SLL and SRL SHALL fill with 0. ROL and ROR SHALL wrap bits.
REQ-008 out_carry for amt = 0 SHALL be 0. Otherwise:
- SLL: in_data[WIDTH-amt].
- SRL/SRA: in_data[amt-1].
- ROL: out_data[0].
- ROR: out_data[WIDTH-1].
REQ-009 out_zero SHALL equal NOR of out_data, computed in the final stage.
REQ-010 Illegal opcode SHALL produce out_data = in_data unchanged, out_carry = 0, out_err = 1.
REQ-011 Stall SHALL be out_valid && !out_ready. On stall every pipeline register, valid bit and tag SHALL hold, and in_ready SHALL be 0. Otherwise in_ready SHALL be 1.
REQ-012 Pipeline bubbles SHALL NOT be compressed during a stall (global stall). Throughput SHALL be one operation per cycle when out_ready is held 1.
REQ-013 Output fields SHALL be stable while out_valid && !out_ready.
REQ-014 Simultaneous output accept and input accept in one cycle SHALL both complete with no loss or duplication.
REQ-015 Results SHALL leave in acceptance order, with out_tag equal to the accepted in_tag.

Reset
REQ-016 While rst = 1 at a clk edge, all stage valid bits SHALL clear, out_valid = 0, and out_data, out_carry, out_zero, out_err, out_tag = 0.
REQ-017 in_ready SHALL be 0 while rst = 1 and 1 in the first cycle after rst deasserts.
REQ-018 Reset mid-operation SHALL discard all in-flight operations; no result from before reset SHALL appear after it.

Structure
REQ-019 Opcode constants (OP_SLL..OP_ROR) SHALL live in the shared package shifter_pkg, reused by the existing ALU decoder.
REQ-020 One sub-module, shift_level, SHALL implement a single parametrised mux level with inputs data, amount bit, op, and fill bit. It SHALL be instantiated log2(WIDTH) times via generate.
REQ-021 Stage payload SHALL be {valid, op, remaining amt bits, data, carry candidate, err, tag}.

Verification
REQ-022 WIDTH=32, SRA, amt=4, data=0x80000010, out_ready=1 -> after 5 cycles out_data=0xF8000001, out_carry=0, out_zero=0.
REQ-023 ROL, amt=1, data=0x80000000 -> out_data=0x00000001, out_carry=1. Then SLL, amt=31, data=0x2 -> out_data=0, out_zero=1, out_carry=1.
REQ-024 Back-to-back 8 operations, tags 0..7, out_ready low for cycles 3–6 -> in_ready low exactly while stalled, and tags emerge 0..7 in order with no loss or duplication.
REQ-025 in_op=110, data=0x1234ABCD -> out_data=0x1234ABCD, out_err=1, out_carry=0.
REQ-026 rst pulsed for one cycle with 3 operations in flight -> out_valid stays 0 until a new post-reset operation completes L cycles later.
REQ-027 Randomised sweep over WIDTH ∈ {8, 32, 64} and REG_EVERY ∈ {1, 2, log2(WIDTH)} against a behavioural model -> zero mismatches, and latency equals L.
